// File: rtl/isq_issue_arbiter.sv
// ----------------------------------------------------------------------------
// isq_issue_arbiter
//
// Picks the older of two issue-queue heads and loads it into a single issue
// stage register that feeds one functional unit.
//
// The FU can run long, non-pipelined ops. While such an op is in flight, the
// arbiter accepts nothing new. A flush kills a stage op that is younger than
// the rollback robid.
//
// Ports
//   i_clock, i_reset              clock; asynchronous active-high reset
//   i_reqN_valid/data/robid/long  issue queue N offers its oldest ready entry
//   o_reqN_ready                  entry N is taken on this clock edge
//   o_fu_valid/data/robid/long/src issue stage contents (src: 0 = req0, 1 = req1)
//   i_fu_ready                    FU accepts the op presented on o_fu_*
//   o_fu_busy                     a long op occupies the FU (busy count != 0)
//   i_flush_valid, i_flush_robid  rollback; ops younger than flush_robid die
//
// Handshake semantics (all three interfaces):
//   A transfer happens on a rising edge exactly when valid && ready are both
//   high in the cycle before that edge. A producer holds valid and its payload
//   stable until the transfer. Ready never depends on anything registered
//   after the edge.
// ----------------------------------------------------------------------------
module isq_issue_arbiter #(
    parameter int DATA_W   = 248,
    parameter int ROBID_W  = 7,
    parameter int LONG_LAT = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,

    input  logic               i_req0_valid,
    input  logic [DATA_W-1:0]  i_req0_data,
    input  logic [ROBID_W-1:0] i_req0_robid,
    input  logic               i_req0_long,
    output logic               o_req0_ready,

    input  logic               i_req1_valid,
    input  logic [DATA_W-1:0]  i_req1_data,
    input  logic [ROBID_W-1:0] i_req1_robid,
    input  logic               i_req1_long,
    output logic               o_req1_ready,

    output logic               o_fu_valid,
    output logic [DATA_W-1:0]  o_fu_data,
    output logic [ROBID_W-1:0] o_fu_robid,
    output logic               o_fu_long,
    output logic               o_fu_src,
    input  logic               i_fu_ready,
    output logic               o_fu_busy,

    input  logic               i_flush_valid,
    input  logic [ROBID_W-1:0] i_flush_robid
);

    // The handshake cycle itself is one cycle of occupancy, so the counter
    // covers the remaining LONG_LAT-1 cycles.
    localparam logic [7:0] BUSY_LOAD = 8'(LONG_LAT - 1);

    // Robids carry a wrap bit in the MSB. When the wrap bits differ, the
    // comparison of the low bits is inverted.
    function automatic logic older(input logic [ROBID_W-1:0] a,
                                   input logic [ROBID_W-1:0] b);
        if (a[ROBID_W-1] == b[ROBID_W-1])
            return a[ROBID_W-2:0] < b[ROBID_W-2:0];
        else
            return a[ROBID_W-2:0] > b[ROBID_W-2:0];
    endfunction

    // Issue stage and long-op occupancy counter
    logic               r_valid;
    logic [DATA_W-1:0]  r_data;
    logic [ROBID_W-1:0] r_robid;
    logic               r_long;
    logic               r_src;
    logic [7:0]         r_busy_cnt;

    logic w_can_accept;
    logic w_sel1;
    logic w_accept;
    logic w_handshake;
    logic w_kill;

    // req1 wins only when it is strictly older. Equal robids go to req0.
    assign w_sel1 = i_req1_valid &&
                    (!i_req0_valid || older(i_req1_robid, i_req0_robid));

    // Reset gating keeps both readys low while reset is asserted.
    assign w_can_accept = !i_reset && !i_flush_valid && (r_busy_cnt == 8'd0) &&
                          (!r_valid || i_fu_ready);

    assign o_req1_ready = w_can_accept && w_sel1;
    assign o_req0_ready = w_can_accept && i_req0_valid && !w_sel1;
    assign w_accept     = o_req0_ready || o_req1_ready;

    assign w_handshake  = r_valid && i_fu_ready;
    // The stage op dies if it is younger than the rollback point, that is,
    // if the flush robid is older than it.
    assign w_kill       = i_flush_valid && r_valid && older(i_flush_robid, r_robid);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_robid    <= '0;
            r_long     <= 1'b0;
            r_src      <= 1'b0;
            r_busy_cnt <= 8'd0;
        end else begin
            // An accept is impossible in a flush cycle, so load and kill never
            // collide. A retire and a load on the same edge give back-to-back
            // issue.
            if (w_accept) begin
                r_valid <= 1'b1;
                r_src   <= w_sel1;
                r_data  <= w_sel1 ? i_req1_data  : i_req0_data;
                r_robid <= w_sel1 ? i_req1_robid : i_req0_robid;
                r_long  <= w_sel1 ? i_req1_long  : i_req0_long;
            end else if (w_handshake || w_kill) begin
                r_valid <= 1'b0;
            end

            // A handshake that coincides with a flush still counts as issued.
            // A flush never touches the counter.
            if (w_handshake && r_long)
                r_busy_cnt <= BUSY_LOAD;
            else if (r_busy_cnt != 8'd0)
                r_busy_cnt <= r_busy_cnt - 8'd1;
        end
    end

    assign o_fu_valid = r_valid;
    assign o_fu_data  = r_data;
    assign o_fu_robid = r_robid;
    assign o_fu_long  = r_long;
    assign o_fu_src   = r_src;
    assign o_fu_busy  = (r_busy_cnt != 8'd0);

endmodule

// File: tb/tb_isq_issue_arbiter.sv
// ----------------------------------------------------------------------------
// tb_isq_issue_arbiter
//
// Directed bench for isq_issue_arbiter with default parameters
// (DATA_W=248, ROBID_W=7, LONG_LAT=8).
//
// Inputs change 1 ns after a rising edge. Combinational readys are sampled
// 1 ns later. Registered outputs are sampled 1 ns after the next rising edge.
// ----------------------------------------------------------------------------
module tb_isq_issue_arbiter;

    localparam int DATA_W  = 248;
    localparam int ROBID_W = 7;

    // Clock and reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               req0_valid = 1'b0;
    logic [DATA_W-1:0]  req0_data  = '0;
    logic [ROBID_W-1:0] req0_robid = '0;
    logic               req0_long  = 1'b0;
    logic               req0_ready;
    logic               req1_valid = 1'b0;
    logic [DATA_W-1:0]  req1_data  = '0;
    logic [ROBID_W-1:0] req1_robid = '0;
    logic               req1_long  = 1'b0;
    logic               req1_ready;
    logic               fu_valid;
    logic [DATA_W-1:0]  fu_data;
    logic [ROBID_W-1:0] fu_robid;
    logic               fu_long;
    logic               fu_src;
    logic               fu_ready = 1'b0;
    logic               fu_busy;
    logic               flush_valid = 1'b0;
    logic [ROBID_W-1:0] flush_robid = '0;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] d_a, d_b, d_x;

    isq_issue_arbiter #(.DATA_W(DATA_W), .ROBID_W(ROBID_W), .LONG_LAT(8)) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_req0_valid  (req0_valid),
        .i_req0_data   (req0_data),
        .i_req0_robid  (req0_robid),
        .i_req0_long   (req0_long),
        .o_req0_ready  (req0_ready),
        .i_req1_valid  (req1_valid),
        .i_req1_data   (req1_data),
        .i_req1_robid  (req1_robid),
        .i_req1_long   (req1_long),
        .o_req1_ready  (req1_ready),
        .o_fu_valid    (fu_valid),
        .o_fu_data     (fu_data),
        .o_fu_robid    (fu_robid),
        .o_fu_long     (fu_long),
        .o_fu_src      (fu_src),
        .i_fu_ready    (fu_ready),
        .o_fu_busy     (fu_busy),
        .i_flush_valid (flush_valid),
        .i_flush_robid (flush_robid)
    );

    // Driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req0(input logic v, input logic [ROBID_W-1:0] id,
                              input logic lng, input logic [DATA_W-1:0] d);
        req0_valid = v; req0_robid = id; req0_long = lng; req0_data = d;
    endtask

    task automatic drive_req1(input logic v, input logic [ROBID_W-1:0] id,
                              input logic lng, input logic [DATA_W-1:0] d);
        req1_valid = v; req1_robid = id; req1_long = lng; req1_data = d;
    endtask

    // Checkers
    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_id(input string tag, input logic [ROBID_W-1:0] obs,
                          input logic [ROBID_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        d_a = '0; d_a[15:0] = 16'hA5A5; d_a[DATA_W-1] = 1'b1;
        d_b = '0; d_b[15:0] = 16'h5A5A; d_b[DATA_W-2] = 1'b1;
        d_x = '0; d_x[31:0] = 32'hDEAD_BEEF;

        // Reset: a valid request must not see ready while reset is held.
        drive_req0(1'b1, 7'h01, 1'b0, d_a);
        fu_ready = 1'b1;
        tick();
        tick();
        chk1("rst_fu_valid", fu_valid, 1'b0);
        chk1("rst_fu_busy", fu_busy, 1'b0);
        chk1("rst_req0_ready", req0_ready, 1'b0);
        chk1("rst_req1_ready", req1_ready, 1'b0);
        chk_id("rst_fu_robid", fu_robid, 7'h00);
        chk_d("rst_fu_data", fu_data, '0);
        chk1("rst_fu_src", fu_src, 1'b0);

        // req1 older (0x03 < 0x05), so req1 is selected.
        rst = 1'b0;
        drive_req0(1'b1, 7'h05, 1'b0, d_a);
        drive_req1(1'b1, 7'h03, 1'b0, d_b);
        fu_ready = 1'b1;
        #1;
        chk1("older_req0_ready", req0_ready, 1'b0);
        chk1("older_req1_ready", req1_ready, 1'b1);
        tick();
        drive_req0(1'b0, 7'h00, 1'b0, '0);
        drive_req1(1'b0, 7'h00, 1'b0, '0);
        chk1("older_fu_valid", fu_valid, 1'b1);
        chk_id("older_fu_robid", fu_robid, 7'h03);
        chk1("older_fu_src", fu_src, 1'b1);
        chk_d("older_fu_data", fu_data, d_b);
        tick();
        chk1("retire_fu_valid", fu_valid, 1'b0);

        // Wrap: req0 0x3E vs req1 0x41. The MSBs differ and 0x01 < 0x3E,
        // so req0 is older.
        drive_req0(1'b1, 7'h3E, 1'b0, d_a);
        drive_req1(1'b1, 7'h41, 1'b0, d_b);
        #1;
        chk1("wrap_req0_ready", req0_ready, 1'b1);
        chk1("wrap_req1_ready", req1_ready, 1'b0);
        tick();
        chk_id("wrap_fu_robid", fu_robid, 7'h3E);
        chk1("wrap_fu_src", fu_src, 1'b0);

        // Equal robids go to req0. The stage retires and loads on one edge.
        drive_req0(1'b1, 7'h20, 1'b0, d_x);
        drive_req1(1'b1, 7'h20, 1'b0, d_b);
        #1;
        chk1("eq_req0_ready", req0_ready, 1'b1);
        chk1("eq_req1_ready", req1_ready, 1'b0);
        tick();
        chk1("b2b_fu_valid", fu_valid, 1'b1);
        chk_id("eq_fu_robid", fu_robid, 7'h20);
        chk_d("eq_fu_data", fu_data, d_x);

        // Only req1 is valid.
        drive_req0(1'b0, 7'h00, 1'b0, '0);
        drive_req1(1'b1, 7'h00, 1'b0, d_b);
        #1;
        chk1("solo_req1_ready", req1_ready, 1'b1);
        chk1("solo_req0_ready", req0_ready, 1'b0);
        tick();
        chk_id("solo_fu_robid", fu_robid, 7'h00);
        chk1("solo_fu_src", fu_src, 1'b1);

        // Stall for 3 cycles with both requests pending.
        fu_ready = 1'b0;
        drive_req0(1'b1, 7'h10, 1'b0, d_x);
        drive_req1(1'b1, 7'h12, 1'b0, d_a);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("stall_req0_ready", req0_ready, 1'b0);
            chk1("stall_req1_ready", req1_ready, 1'b0);
            tick();
            chk1("stall_fu_valid", fu_valid, 1'b1);
            chk_id("stall_fu_robid", fu_robid, 7'h00);
            chk1("stall_fu_src", fu_src, 1'b1);
            chk_d("stall_fu_data", fu_data, d_b);
        end
        fu_ready = 1'b1;
        #1;
        chk1("unstall_req0_ready", req0_ready, 1'b1);
        tick();
        chk_id("unstall_fu_robid", fu_robid, 7'h10);
        chk1("unstall_fu_src", fu_src, 1'b0);
        chk_d("unstall_fu_data", fu_data, d_x);

        // A flush at an equal robid keeps the stage and blocks accept.
        fu_ready = 1'b0;
        drive_req0(1'b0, 7'h00, 1'b0, '0);
        drive_req1(1'b1, 7'h30, 1'b0, d_a);
        flush_valid = 1'b1;
        flush_robid = 7'h10;
        #1;
        chk1("flush_blocks_req1", req1_ready, 1'b0);
        tick();
        chk1("flush_eq_kept", fu_valid, 1'b1);
        chk_id("flush_eq_robid", fu_robid, 7'h10);
        // Stage 0x10 is younger than 0x0C, so the flush kills it.
        drive_req1(1'b0, 7'h00, 1'b0, '0);
        flush_robid = 7'h0C;
        tick();
        chk1("flush_kill_fu_valid", fu_valid, 1'b0);

        // Load a long op.
        flush_valid = 1'b0;
        drive_req0(1'b1, 7'h20, 1'b1, d_a);
        #1;
        chk1("long_req0_ready", req0_ready, 1'b1);
        tick();
        chk1("long_fu_valid", fu_valid, 1'b1);
        chk1("long_fu_long", fu_long, 1'b1);
        // The handshake and a killing flush land on the same edge. The op
        // counts as issued and the stage clears.
        fu_ready = 1'b1;
        flush_valid = 1'b1;
        flush_robid = 7'h18;
        drive_req0(1'b1, 7'h21, 1'b1, d_b);
        #1;
        chk1("hsflush_req0_ready", req0_ready, 1'b0);
        tick();
        flush_valid = 1'b0;
        chk1("hsflush_fu_valid", fu_valid, 1'b0);
        // Busy lasts 7 cycles, so the next accept comes 8 cycles after the
        // handshake.
        for (int k = 1; k <= 7; k++) begin
            #1;
            chk1("busy_fu_busy", fu_busy, 1'b1);
            chk1("busy_req0_ready", req0_ready, 1'b0);
            tick();
        end
        #1;
        chk1("drain_fu_busy", fu_busy, 1'b0);
        chk1("drain_req0_ready", req0_ready, 1'b1);
        tick();
        chk_id("drain_fu_robid", fu_robid, 7'h21);

        // Retire the long op 0x21 and load 0x22 on the same edge.
        drive_req0(1'b1, 7'h22, 1'b0, d_x);
        #1;
        chk1("b2b_long_req0_ready", req0_ready, 1'b1);
        tick();
        chk1("pre_rst_fu_valid", fu_valid, 1'b1);
        chk1("pre_rst_fu_busy", fu_busy, 1'b1);
        chk_id("pre_rst_fu_robid", fu_robid, 7'h22);

        // Reset mid-cycle clears the stage and the busy count at once.
        fu_ready = 1'b0;
        drive_req0(1'b1, 7'h23, 1'b0, d_a);
        #2;
        rst = 1'b1;
        #1;
        chk1("async_rst_fu_valid", fu_valid, 1'b0);
        chk1("async_rst_fu_busy", fu_busy, 1'b0);
        chk1("async_rst_req0_ready", req0_ready, 1'b0);
        chk_id("async_rst_fu_robid", fu_robid, 7'h00);
        tick();
        rst = 1'b0;
        #1;
        chk1("post_rst_req0_ready", req0_ready, 1'b1);
        tick();
        chk1("post_rst_fu_valid", fu_valid, 1'b1);
        chk_id("post_rst_fu_robid", fu_robid, 7'h23);
        chk_d("post_rst_fu_data", fu_data, d_a);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the directed sequence completed");
        $fatal(1, "watchdog");
    end

endmodule
